debug_unit_receive: RTL and testbench

Host-to-target half of the MIPS debug link. Consumes bytes from the UART receiver, decodes single-byte host commands, and assembles LSB-first 32-bit words into instruction-memory writes during program load. Drives CPU run/step control and execution mode toward debug_unit_transmit and the pipeline. Waits for the transmitter's dump-complete before accepting the next step.

---
 rtl/debug_unit_pkg.sv | 21 ++
 rtl/debug_rx_word_assembler.sv | 42 ++++
 rtl/debug_unit_receive.sv | 154 +++++++++++++++
 tb/tb_debug_unit_receive.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_unit_pkg.sv
// Shared encodings for the debug link: state codes (also used by the transmit side),
// host command bytes and the program terminator word.
package debug_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP      = 3'd3,
    ST_STEP_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_rx_word_assembler.sv
// Packs LSB-first bytes into a word; word_valid pulses the cycle after the last byte.
// A byte may arrive during the word_valid cycle and starts the next word.
module debug_rx_word_assembler #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || clear) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        // First byte zeroes the upper lanes so no stale data survives an abort.
        if (cnt == '0) word <= WORD_W'(byte_data);
        else           word[cnt*BYTE_W +: BYTE_W] <= byte_data;
        if (cnt == CNT_W'(NBYTES-1)) begin
          cnt        <= '0;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_unit_receive.sv
module debug_unit_receive
  import debug_unit_pkg::*;
#(
  parameter int          N_BITS_INSTR   = 32,
  parameter int          N_BITS_UART    = 8,
  parameter int          N_BITS_ADDR    = 32,
  parameter int          MEM_DEPTH      = 64,
  parameter logic [31:0] HALT_INSTR     = HALT_WORD,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          NB_STATE       = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_BITS_UART-1:0]  i_uart_rx_data,
  input  logic                    i_uart_rx_done,
  input  logic                    i_halt,
  input  logic                    i_tx_done,
  output logic [N_BITS_INSTR-1:0] o_instr_data,
  output logic [N_BITS_ADDR-1:0]  o_instr_addr,
  output logic                    o_instr_write_en,
  output logic                    o_execution_mode,
  output logic                    o_cpu_enable,
  output logic                    o_step,
  output logic                    o_program_loaded,
  output logic                    o_load_error,
  output logic [NB_STATE-1:0]     o_state
);

  localparam int IDX_W = $clog2(MEM_DEPTH) + 1;

  state_t             state;
  logic [IDX_W-1:0]   word_idx;
  logic               halt_seen;
  logic               word_valid;
  logic               asm_clear;
  logic               load_cmd;
  logic               tmo_hit;
  logic [7:0]         rx_byte;

  assign rx_byte  = 8'(i_uart_rx_data);
  assign load_cmd = (state == ST_IDLE) && i_uart_rx_done && (rx_byte == CMD_LOAD);

`ifdef DEBUG_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || state != ST_LOAD || i_uart_rx_done) tmo_cnt <= '0;
    else if (!tmo_hit)                                 tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == ST_LOAD) && !i_uart_rx_done &&
                   (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign asm_clear = load_cmd || tmo_hit;

  debug_rx_word_assembler #(
    .WORD_W (N_BITS_INSTR),
    .BYTE_W (N_BITS_UART)
  ) u_asm (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .clear      (asm_clear),
    .byte_valid (i_uart_rx_done && state == ST_LOAD),
    .byte_data  (i_uart_rx_data),
    .word       (o_instr_data),
    .word_valid (word_valid)
  );

  assign o_instr_write_en = word_valid;
  assign o_instr_addr     = N_BITS_ADDR'({word_idx, 2'b00});
  assign o_state          = NB_STATE'(state);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= ST_IDLE;
      word_idx         <= '0;
      halt_seen        <= 1'b0;
      o_execution_mode <= 1'b0;
      o_cpu_enable     <= 1'b0;
      o_step           <= 1'b0;
      o_program_loaded <= 1'b0;
      o_load_error     <= 1'b0;
    end else begin
      o_step <= 1'b0;
      unique case (state)
        ST_IDLE: if (i_uart_rx_done) begin
          if (rx_byte == CMD_LOAD) begin
            state            <= ST_LOAD;
            word_idx         <= '0;
            o_program_loaded <= 1'b0;
            o_load_error     <= 1'b0;
          end else if (rx_byte == CMD_CONT && o_program_loaded) begin
            state            <= ST_RUN;
            o_execution_mode <= 1'b0;
            o_cpu_enable     <= 1'b1;
          end else if (rx_byte == CMD_STEP && o_program_loaded) begin
            state            <= ST_STEP;
            o_execution_mode <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            word_idx <= word_idx + 1'b1;
            if (o_instr_data == N_BITS_INSTR'(HALT_INSTR)) begin
              o_program_loaded <= 1'b1;
              state            <= ST_IDLE;
            end else if (word_idx == IDX_W'(MEM_DEPTH - 1)) begin
              o_load_error     <= 1'b1;
              o_program_loaded <= 1'b0;
              state            <= ST_IDLE;
            end
          end else if (tmo_hit) begin
            o_load_error     <= 1'b1;
            o_program_loaded <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        ST_RUN: if (i_halt) begin
          o_cpu_enable <= 1'b0;
          state        <= ST_IDLE;
        end
        ST_STEP: if (i_uart_rx_done) begin
          if (rx_byte == CMD_NEXT) begin
            o_step       <= 1'b1;
            o_cpu_enable <= 1'b1;
            halt_seen    <= 1'b0;
            state        <= ST_STEP_WAIT;
          end else if (rx_byte == CMD_EXIT) begin
            o_execution_mode <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        ST_STEP_WAIT: begin
          o_cpu_enable <= 1'b0;
          if (i_halt) halt_seen <= 1'b1;
          if (i_tx_done) begin
            if (halt_seen || i_halt) begin
              o_execution_mode <= 1'b0;
              state            <= ST_IDLE;
            end else begin
              state <= ST_STEP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit_receive.sv
module tb_debug_unit_receive;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done, halt, tx_done;
  logic [31:0] instr_data, instr_addr;
  logic        wen, mode, cpu_en, step, loaded, lerr;
  logic [2:0]  state;

  always #5 clk = ~clk;

  debug_unit_receive #(.TIMEOUT_CYCLES(100)) dut (
    .i_clock(clk), .i_reset(rst), .i_uart_rx_data(rx_data), .i_uart_rx_done(rx_done),
    .i_halt(halt), .i_tx_done(tx_done), .o_instr_data(instr_data), .o_instr_addr(instr_addr),
    .o_instr_write_en(wen), .o_execution_mode(mode), .o_cpu_enable(cpu_en), .o_step(step),
    .o_program_loaded(loaded), .o_load_error(lerr), .o_state(state)
  );

  int nchk = 0, nerr = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  bit exp_loaded, exp_err;
  int step_cnt = 0, en_cnt = 0;

  always @(negedge clk) begin
    if (wen) obs_q.push_back({instr_addr, instr_data});
    if (step) step_cnt++;
    if (cpu_en) en_cnt++;
  end

  function automatic void model_load(input logic [31:0] w[$]);
    exp_q.delete(); exp_loaded = 0; exp_err = 0;
    foreach (w[i]) begin
      exp_q.push_back({32'(i * 4), w[i]});
      if (w[i] == 32'hFFFF_FFFF) begin exp_loaded = 1; return; end
      if (exp_q.size() == 64) begin exp_err = 1; return; end
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] v = $urandom;
    if (v == 32'hFFFF_FFFF) v = 32'h1234_5678;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; tick(2); rst = 1'b0; tick(1);
  endtask

  task automatic send_program(input logic [31:0] w[$]);
    obs_q.delete();
    model_load(w);
    send_byte(8'h4C, $urandom_range(0, 2));
    foreach (w[i])
      for (int k = 0; k < 4; k++) send_byte(w[i][8*k +: 8], $urandom_range(0, 3));
    tick(4);
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if ({wen, mode, cpu_en, step, loaded, lerr, state} !== 9'b0) begin
      nerr++; $display("FAIL reset_outputs got %b want 0", {wen, mode, cpu_en, step, loaded, lerr, state});
    end
  endtask

  task automatic test_ignore_idle();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      if (b == 8'h4C || b == 8'h43 || b == 8'h53) b = 8'h00;
      send_byte(b, 0);
    end
    send_byte(8'h43, 1);
    send_byte(8'h53, 1);
    nchk++;
    if (state !== 3'd0 || cpu_en !== 1'b0) begin
      nerr++; $display("FAIL idle_ignore state %0d cpu_en %b want 0 0", state, cpu_en);
    end
  endtask

  task automatic test_load_basic();
    logic [31:0] w[$];
    w = '{32'h2401_0020, 32'hFFFF_FFFF};
    send_program(w);
    nchk++;
    if (obs_q.size() != 2 || obs_q[0] !== {32'd0, 32'h2401_0020} || obs_q[1] !== {32'd4, 32'hFFFF_FFFF}) begin
      nerr++; $display("FAIL load_basic_writes got %0d writes first %h want 2 writes first %h",
                       obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, {32'd0, 32'h2401_0020});
    end
    nchk++;
    if (loaded !== 1'b1 || lerr !== 1'b0 || state !== 3'd0) begin
      nerr++; $display("FAIL load_basic_flags loaded %b err %b state %0d want 1 0 0", loaded, lerr, state);
    end
  endtask

  task automatic test_load_random();
    logic [31:0] w[$];
    for (int t = 0; t < 4; t++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(0, 9); i++) w.push_back(rand_word());
      w.push_back(32'hFFFF_FFFF);
      send_program(w);
      nchk++;
      if (obs_q.size() != exp_q.size()) begin
        nerr++; $display("FAIL load_random_count got %0d want %0d", obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
          nerr++; $display("FAIL load_random_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
          break;
        end
      end
      nchk++;
      if (loaded !== exp_loaded || lerr !== exp_err || state !== 3'd0) begin
        nerr++; $display("FAIL load_random_flags loaded %b err %b state %0d want %b %b 0",
                         loaded, lerr, state, exp_loaded, exp_err);
      end
    end
  endtask

  task automatic test_run();
    send_byte(8'h43, 0);
    nchk++;
    if (state !== 3'd2 || cpu_en !== 1'b1 || mode !== 1'b0) begin
      nerr++; $display("FAIL run_entry state %0d cpu_en %b mode %b want 2 1 0", state, cpu_en, mode);
    end
    send_byte(8'h53, 2);
    nchk++;
    if (state !== 3'd2 || cpu_en !== 1'b1) begin
      nerr++; $display("FAIL run_ignore state %0d cpu_en %b want 2 1", state, cpu_en);
    end
    @(negedge clk); halt = 1'b1; rx_data = 8'h4C; rx_done = 1'b1;
    @(negedge clk); halt = 1'b0; rx_done = 1'b0;
    nchk++;
    if (state !== 3'd0 || cpu_en !== 1'b0 || loaded !== 1'b1) begin
      nerr++; $display("FAIL run_halt state %0d cpu_en %b loaded %b want 0 0 1", state, cpu_en, loaded);
    end
  endtask

  task automatic test_step();
    int s0, e0;
    send_byte(8'h53, 0);
    nchk++;
    if (state !== 3'd3 || mode !== 1'b1 || cpu_en !== 1'b0) begin
      nerr++; $display("FAIL step_entry state %0d mode %b cpu_en %b want 3 1 0", state, mode, cpu_en);
    end
    s0 = step_cnt; e0 = en_cnt;
    send_byte(8'h4E, 4);
    nchk++;
    if (step_cnt - s0 != 1 || en_cnt - e0 != 1 || state !== 3'd4) begin
      nerr++; $display("FAIL step_pulse step %0d en %0d state %0d want 1 1 4", step_cnt - s0, en_cnt - e0, state);
    end
    s0 = step_cnt; e0 = en_cnt;
    send_byte(8'h4E, 3);
    nchk++;
    if (step_cnt != s0 || en_cnt != e0 || state !== 3'd4) begin
      nerr++; $display("FAIL step_wait_ignore step %0d en %0d state %0d want 0 0 4", step_cnt - s0, en_cnt - e0, state);
    end
    @(negedge clk); tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
    nchk++;
    if (state !== 3'd3 || mode !== 1'b1) begin
      nerr++; $display("FAIL step_resume state %0d mode %b want 3 1", state, mode);
    end
    send_byte(8'h43, 1);
    send_byte(8'h4E, 1);
    @(negedge clk); halt = 1'b1; @(negedge clk); halt = 1'b0; tick(2);
    @(negedge clk); tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
    nchk++;
    if (state !== 3'd0 || mode !== 1'b0) begin
      nerr++; $display("FAIL step_halt state %0d mode %b want 0 0", state, mode);
    end
    send_byte(8'h53, 1);
    send_byte(8'h45, 1);
    nchk++;
    if (state !== 3'd0 || mode !== 1'b0 || cpu_en !== 1'b0) begin
      nerr++; $display("FAIL step_exit state %0d mode %b cpu_en %b want 0 0 0", state, mode, cpu_en);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    bit addr_ok = 1;
    for (int i = 0; i < 64; i++) w.push_back(rand_word());
    send_program(w);
    nchk++;
    if (obs_q.size() != 64) begin
      nerr++; $display("FAIL overflow_count got %0d want 64", obs_q.size());
    end else begin
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) addr_ok = 0;
      if (!addr_ok) begin
        nerr++; $display("FAIL overflow_writes last got %h want %h", obs_q[63], exp_q[63]);
      end
    end
    nchk++;
    if (lerr !== 1'b1 || loaded !== 1'b0 || state !== 3'd0) begin
      nerr++; $display("FAIL overflow_flags err %b loaded %b state %0d want 1 0 0", lerr, loaded, state);
    end
    send_byte(8'h43, 1);
    nchk++;
    if (state !== 3'd0 || cpu_en !== 1'b0) begin
      nerr++; $display("FAIL overflow_no_run state %0d cpu_en %b want 0 0", state, cpu_en);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w[$];
    obs_q.delete();
    send_byte(8'h4C, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    nchk++;
    if (loaded !== 1'b0 || state !== 3'd0 || obs_q.size() != 0) begin
      nerr++; $display("FAIL reset_midload loaded %b state %0d writes %0d want 0 0 0", loaded, state, obs_q.size());
    end
    w = '{rand_word(), 32'hFFFF_FFFF};
    send_program(w);
    nchk++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || loaded !== 1'b1) begin
      nerr++; $display("FAIL reset_reload got %0d writes first %h loaded %b want 2 %h 1",
                       obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, loaded, exp_q[0]);
    end
  endtask

`ifdef DEBUG_RX_TIMEOUT_EN
  task automatic test_timeout();
    obs_q.delete();
    send_byte(8'h4C, 0);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
    tick(102);
    nchk++;
    if (lerr !== 1'b1 || loaded !== 1'b0 || state !== 3'd0 || obs_q.size() != 0) begin
      nerr++; $display("FAIL timeout err %b loaded %b state %0d writes %0d want 1 0 0 0",
                       lerr, loaded, state, obs_q.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1; rx_data = '0; rx_done = 1'b0; halt = 1'b0; tx_done = 1'b0;
    test_reset();
    test_ignore_idle();
    test_load_basic();
    test_run();
    test_step();
    test_load_random();
    test_overflow();
    test_reset_midload();
`ifdef DEBUG_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
